// File: rtl/prim_count_pkg.sv
// Shared types for the hardened counter primitives.
//   cnt_mode_e    : per-channel overflow policy (saturate or modulo wrap)
//   action_mask_t : which counter actions an instance may ever see
//   Clr/Set/Incr/Decr : one-hot bits of action_mask_t
package prim_count_pkg;

  typedef enum logic {
    CntSat  = 1'b0,
    CntWrap = 1'b1
  } cnt_mode_e;

  typedef logic [3:0] action_mask_t;

  localparam action_mask_t Clr  = 4'b0001;
  localparam action_mask_t Set  = 4'b0010;
  localparam action_mask_t Incr = 4'b0100;
  localparam action_mask_t Decr = 4'b1000;

endpackage

// File: rtl/prim_count_lane.sv
// One hardened counter channel: an up-counting primary paired with a
// down-counting secondary whose sum must always equal all-ones.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   clr_i, set_i       : clear to ResetValue / load set_cnt_i (clr wins)
//   incr_en_i/decr_en_i: step by step_i (both set = hold)
//   commit_i           : state only updates when high
//   tc_val_i           : terminal-count compare value
//   cnt_o              : primary count
//   cnt_after_commit_o : primary count that a commit would produce
//   tc_o, wrap_o       : registered one-cycle event pulses
//   err_o              : combinational primary/secondary cross-check failure
module prim_count_lane
  import prim_count_pkg::*;
#(
  parameter int unsigned      Width           = 8,
  parameter logic [Width-1:0] ResetValue      = '0,
  parameter cnt_mode_e        Mode            = CntSat,
  parameter action_mask_t     PossibleActions = '1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             set_i,
  input  logic [Width-1:0] set_cnt_i,
  input  logic             incr_en_i,
  input  logic             decr_en_i,
  input  logic [Width-1:0] step_i,
  input  logic             commit_i,
  input  logic [Width-1:0] tc_val_i,
  output logic [Width-1:0] cnt_o,
  output logic [Width-1:0] cnt_after_commit_o,
  output logic             tc_o,
  output logic             wrap_o,
  output logic             err_o
);

  localparam logic [Width-1:0] MaxVal = '1;
  localparam bit               Sat    = (Mode == CntSat);

  logic [Width-1:0] prim_q, sec_q, sec_val, fpv_force;
  logic [Width-1:0] prim_d, sec_d;
  logic [Width:0]   prim_up, prim_dn, sec_up, sec_dn, cross_sum;
  logic             up, dn, prim_gate, wrap_ev;
  logic             tc_q, wrap_q;

  // Formal can drive fpv_force freely to corrupt the secondary.
`ifndef PrimCountFpv
  assign fpv_force = '0;
`endif
  assign sec_val = sec_q ^ fpv_force;

  always_comb begin
    up      = incr_en_i & ~decr_en_i;
    dn      = decr_en_i & ~incr_en_i;
    prim_up = {1'b0, prim_q} + {1'b0, step_i};
    prim_dn = {1'b0, prim_q} - {1'b0, step_i};
    sec_up  = {1'b0, sec_val} + {1'b0, step_i};
    sec_dn  = {1'b0, sec_val} - {1'b0, step_i};
    // A saturating counter already at the rail it is pushed against is
    // frozen, so it cannot report a second clamp event.
    prim_gate = Sat && ((up && prim_q == MaxVal) || (dn && prim_q == '0));

    prim_d  = prim_q;
    sec_d   = sec_val;
    wrap_ev = 1'b0;
    if (clr_i) begin
      prim_d = ResetValue;
      sec_d  = MaxVal - ResetValue;
    end else if (set_i) begin
      prim_d = set_cnt_i;
      sec_d  = MaxVal - set_cnt_i;
    end else if (up) begin
      if (!prim_gate) begin
        wrap_ev = prim_up[Width];
        prim_d  = (prim_up[Width] && Sat) ? MaxVal : prim_up[Width-1:0];
      end
      sec_d = (sec_dn[Width] && Sat) ? '0 : sec_dn[Width-1:0];
    end else if (dn) begin
      if (!prim_gate) begin
        wrap_ev = prim_dn[Width];
        prim_d  = (prim_dn[Width] && Sat) ? '0 : prim_dn[Width-1:0];
      end
      sec_d = (sec_up[Width] && Sat) ? MaxVal : sec_up[Width-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prim_q <= ResetValue;
      sec_q  <= MaxVal - ResetValue;
      tc_q   <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      if (commit_i) begin
        prim_q <= prim_d;
        sec_q  <= sec_d;
      end
      tc_q   <= commit_i && (prim_d == tc_val_i) && (prim_q != tc_val_i);
      wrap_q <= commit_i && wrap_ev;
    end
  end

  assign cross_sum          = {1'b0, prim_q} + {1'b0, sec_val};
  assign err_o              = (cross_sum != {1'b0, MaxVal});
  assign cnt_o              = prim_q;
  assign cnt_after_commit_o = prim_d;
  assign tc_o               = tc_q;
  assign wrap_o             = wrap_q;

  a_clr_possible: assert property (@(posedge clk_i) disable iff (rst_i)
    (!clr_i || ((PossibleActions & Clr) != '0)));
  a_set_possible: assert property (@(posedge clk_i) disable iff (rst_i)
    (!set_i || ((PossibleActions & Set) != '0)));
  a_incr_possible: assert property (@(posedge clk_i) disable iff (rst_i)
    (!incr_en_i || ((PossibleActions & Incr) != '0)));
  a_decr_possible: assert property (@(posedge clk_i) disable iff (rst_i)
    (!decr_en_i || ((PossibleActions & Decr) != '0)));

endmodule

// File: rtl/prim_count_array.sv
// N-channel hardened cross-counter array with a shared sticky error.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   clr_i/set_i/incr_en_i/decr_en_i/commit_i : per-channel controls
//   set_cnt_i/step_i/tc_val_i : per-channel Width-bit fields, channel k at [k*Width +: Width]
//   cnt_o, cnt_after_commit_o : per-channel current / prospective counts
//   tc_o, wrap_o        : per-channel registered event pulses
//   err_o               : per-channel combinational cross-check failure
//   err_sticky_o        : latched OR of err_o, cleared only by reset
module prim_count_array
  import prim_count_pkg::*;
#(
  parameter int unsigned      NumCh           = 4,
  parameter int unsigned      Width           = 8,
  parameter logic [Width-1:0] ResetValue      = '0,
  parameter logic [NumCh-1:0] Mode            = {NumCh{CntSat}},
  parameter action_mask_t     PossibleActions = '1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumCh-1:0]       clr_i,
  input  logic [NumCh-1:0]       set_i,
  input  logic [NumCh*Width-1:0] set_cnt_i,
  input  logic [NumCh-1:0]       incr_en_i,
  input  logic [NumCh-1:0]       decr_en_i,
  input  logic [NumCh*Width-1:0] step_i,
  input  logic [NumCh-1:0]       commit_i,
  input  logic [NumCh*Width-1:0] tc_val_i,
  output logic [NumCh*Width-1:0] cnt_o,
  output logic [NumCh*Width-1:0] cnt_after_commit_o,
  output logic [NumCh-1:0]       tc_o,
  output logic [NumCh-1:0]       wrap_o,
  output logic [NumCh-1:0]       err_o,
  output logic                   err_sticky_o
);

  logic [NumCh-1:0] err;
  logic             err_sticky_q;

  for (genvar k = 0; k < NumCh; k++) begin : g_lane
    prim_count_lane #(
      .Width           (Width),
      .ResetValue      (ResetValue),
      .Mode            (cnt_mode_e'(Mode[k])),
      .PossibleActions (PossibleActions)
    ) u_lane (
      .clk_i              (clk_i),
      .rst_i              (rst_i),
      .clr_i              (clr_i[k]),
      .set_i              (set_i[k]),
      .set_cnt_i          (set_cnt_i[k*Width +: Width]),
      .incr_en_i          (incr_en_i[k]),
      .decr_en_i          (decr_en_i[k]),
      .step_i             (step_i[k*Width +: Width]),
      .commit_i           (commit_i[k]),
      .tc_val_i           (tc_val_i[k*Width +: Width]),
      .cnt_o              (cnt_o[k*Width +: Width]),
      .cnt_after_commit_o (cnt_after_commit_o[k*Width +: Width]),
      .tc_o               (tc_o[k]),
      .wrap_o             (wrap_o[k]),
      .err_o              (err[k])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_sticky_q <= 1'b0;
    end else begin
      err_sticky_q <= err_sticky_q | (|err);
    end
  end

  assign err_o        = err;
  assign err_sticky_o = err_sticky_q;

endmodule

// File: tb/tb_prim_count_array.sv
// Randomized plus directed bench for prim_count_array (4 channels, 4 bits,
// ch0/ch3 saturating, ch1/ch2 wrapping) against an integer reference model.
module tb_prim_count_array;
  import prim_count_pkg::*;

  localparam int NCH  = 4;
  localparam int W    = 4;
  localparam int MAXV = 15;

  logic               clk = 1'b0;
  logic               rst_i;
  logic [NCH-1:0]     clr_i, set_i, incr_en_i, decr_en_i, commit_i;
  logic [NCH*W-1:0]   set_cnt_i, step_i, tc_val_i;
  logic [NCH*W-1:0]   cnt_o, cnt_after_commit_o;
  logic [NCH-1:0]     tc_o, wrap_o, err_o;
  logic               err_sticky_o;

  always #5 clk = ~clk;

  prim_count_array #(
    .NumCh      (NCH),
    .Width      (W),
    .ResetValue (4'h0),
    .Mode       ({CntSat, CntWrap, CntWrap, CntSat})
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .clr_i              (clr_i),
    .set_i              (set_i),
    .set_cnt_i          (set_cnt_i),
    .incr_en_i          (incr_en_i),
    .decr_en_i          (decr_en_i),
    .step_i             (step_i),
    .commit_i           (commit_i),
    .tc_val_i           (tc_val_i),
    .cnt_o              (cnt_o),
    .cnt_after_commit_o (cnt_after_commit_o),
    .tc_o               (tc_o),
    .wrap_o             (wrap_o),
    .err_o              (err_o),
    .err_sticky_o       (err_sticky_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: counts as plain integers; the secondary is implied as MAXV - count.
  int m_cnt[NCH];
  bit m_tc[NCH];
  bit m_wrap[NCH];
  bit m_sticky;
  bit m_forced3 = 1'b0;
  bit m_valid   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_wrap(input int k);
    return (k == 1) || (k == 2);
  endfunction

  function automatic void model_op(input int k, output int nxt, output bit w);
    int cnt;
    int st;
    int ideal;
    cnt = m_cnt[k];
    st  = int'(step_i[k*W +: W]);
    nxt = cnt;
    w   = 1'b0;
    if (clr_i[k]) begin
      nxt = 0;
    end else if (set_i[k]) begin
      nxt = int'(set_cnt_i[k*W +: W]);
    end else if (incr_en_i[k] != decr_en_i[k]) begin
      ideal = incr_en_i[k] ? cnt + st : cnt - st;
      if (ideal > MAXV || ideal < 0) begin
        if (is_wrap(k)) begin
          nxt = (ideal + MAXV + 1) % (MAXV + 1);
          w   = 1'b1;
        end else begin
          nxt = (ideal > MAXV) ? MAXV : 0;
          w   = (nxt != cnt);
        end
      end else begin
        nxt = ideal;
      end
    end
  endfunction

  task automatic step_cycle();
    int nxt[NCH];
    bit w[NCH];
    int tcv;
    int n_cnt[NCH];
    bit n_tc[NCH];
    bit n_wrap[NCH];
    bit n_sticky;
    #1;
    for (int k = 0; k < NCH; k++) model_op(k, nxt[k], w[k]);
    if (m_valid) begin
      for (int k = 0; k < NCH; k++)
        check($sformatf("after_commit%0d", k), 32'(cnt_after_commit_o[k*W +: W]), nxt[k]);
      check("err_o", 32'(err_o), m_forced3 ? 32'h8 : 32'h0);
    end
    if (rst_i) begin
      for (int k = 0; k < NCH; k++) begin
        n_cnt[k] = 0; n_tc[k] = 1'b0; n_wrap[k] = 1'b0;
      end
      n_sticky = 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        tcv       = int'(tc_val_i[k*W +: W]);
        n_tc[k]   = commit_i[k] && (nxt[k] == tcv) && (m_cnt[k] != tcv);
        n_wrap[k] = commit_i[k] && w[k];
        n_cnt[k]  = commit_i[k] ? nxt[k] : m_cnt[k];
      end
      n_sticky = m_sticky | m_forced3;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NCH; k++) begin
      m_cnt[k] = n_cnt[k]; m_tc[k] = n_tc[k]; m_wrap[k] = n_wrap[k];
    end
    m_sticky = n_sticky;
    m_valid  = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      check($sformatf("cnt%0d", k), 32'(cnt_o[k*W +: W]), m_cnt[k]);
      check($sformatf("tc%0d", k), 32'(tc_o[k]), 32'(m_tc[k]));
      check($sformatf("wrap%0d", k), 32'(wrap_o[k]), 32'(m_wrap[k]));
    end
    check("err_sticky", 32'(err_sticky_o), 32'(m_sticky));
    check("sec0", 32'(dut.g_lane[0].u_lane.sec_q), MAXV - m_cnt[0]);
    check("sec1", 32'(dut.g_lane[1].u_lane.sec_q), MAXV - m_cnt[1]);
  endtask

  task automatic idle();
    rst_i     = 1'b0;
    clr_i     = '0;
    set_i     = '0;
    incr_en_i = '0;
    decr_en_i = '0;
    commit_i  = '0;
    set_cnt_i = '0;
    step_i    = '0;
  endtask

  task automatic do_set(input int k, input int v);
    set_i[k] = 1'b1;
    set_cnt_i[k*W +: W] = W'(v);
    commit_i[k] = 1'b1;
  endtask

  task automatic do_incr(input int k, input int s, input bit c);
    incr_en_i[k] = 1'b1;
    step_i[k*W +: W] = W'(s);
    commit_i[k] = c;
  endtask

  int r;

  initial begin
    idle();
    tc_val_i = '0;
    for (int k = 0; k < NCH; k++) m_cnt[k] = 0;
    rst_i = 1'b1;
    step_cycle();
    step_cycle();
    idle();
    step_cycle();
    check("rst_cnt", 32'(cnt_o), 32'h0);
    check("rst_err", 32'(err_o), 32'h0);
    check("rst_sticky", 32'(err_sticky_o), 32'h0);

    // Saturating channel: clamp once, then stay frozen at the rail.
    idle(); do_set(0, 14); step_cycle();
    idle(); do_incr(0, 3, 1'b1); step_cycle();
    check("sat_clamp", 32'(cnt_o[3:0]), 15);
    check("sat_wrap", 32'(wrap_o[0]), 1);
    idle(); do_incr(0, 3, 1'b1); step_cycle();
    check("sat_hold", 32'(cnt_o[3:0]), 15);
    check("sat_no_wrap", 32'(wrap_o[0]), 0);

    // Wrapping channel: carry out and a borrow back.
    idle(); do_set(1, 14); step_cycle();
    idle(); do_incr(1, 3, 1'b1); step_cycle();
    check("wrap_cnt", 32'(cnt_o[7:4]), 1);
    check("wrap_sec", 32'(dut.g_lane[1].u_lane.sec_q), 14);
    check("wrap_pulse", 32'(wrap_o[1]), 1);
    idle(); decr_en_i[1] = 1'b1; step_i[7:4] = 4'd2; commit_i[1] = 1'b1; step_cycle();
    check("borrow_cnt", 32'(cnt_o[7:4]), 15);

    // Terminal count.
    idle(); tc_val_i[3:0] = 4'd5; do_set(0, 3); step_cycle();
    idle(); do_incr(0, 1, 1'b1); step_cycle();
    check("tc_early", 32'(tc_o[0]), 0);
    idle(); do_incr(0, 1, 1'b1); step_cycle();
    check("tc_hit", 32'(tc_o[0]), 1);
    idle(); do_incr(0, 1, 1'b1); decr_en_i[0] = 1'b1; step_cycle();
    check("tc_hold_cnt", 32'(cnt_o[3:0]), 5);
    check("tc_hold_pulse", 32'(tc_o[0]), 0);

    // Uncommitted increment, then clear beating set and incr.
    idle(); do_set(2, 6); step_cycle();
    idle(); do_incr(2, 5, 1'b0); step_cycle();
    check("nocommit_cnt", 32'(cnt_o[11:8]), 6);
    idle(); clr_i[2] = 1'b1; do_set(2, 9); do_incr(2, 1, 1'b1); step_cycle();
    check("clr_prio", 32'(cnt_o[11:8]), 0);

    // Random traffic on all channels.
    for (int c = 0; c < 300; c++) begin
      idle();
      rst_i = ($urandom_range(0, 59) == 0);
      for (int k = 0; k < NCH; k++) begin
        r = int'($urandom_range(0, 15));
        tc_val_i[k*W +: W] = W'(m_cnt[k] + int'($urandom_range(0, 3)));
        step_i[k*W +: W]   = ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom_range(1, 6));
        commit_i[k]        = ($urandom_range(0, 3) != 0);
        if (r == 0) clr_i[k] = 1'b1;
        else if (r == 1) begin
          set_i[k] = 1'b1;
          set_cnt_i[k*W +: W] = W'($urandom_range(0, 15));
        end else if (r == 2) begin
          incr_en_i[k] = 1'b1; decr_en_i[k] = 1'b1;
        end else if (r < 9) incr_en_i[k] = 1'b1;
        else decr_en_i[k] = 1'b1;
      end
      step_cycle();
    end

    // Corrupt ch3's secondary: immediate error, sticky survives repair.
    idle();
    m_forced3 = 1'b1;
    force dut.g_lane[3].u_lane.fpv_force = 4'h1;
    step_cycle();
    check("force_sticky", 32'(err_sticky_o), 1);
    release dut.g_lane[3].u_lane.fpv_force;
    m_forced3 = 1'b0;
    idle(); clr_i[3] = 1'b1; commit_i[3] = 1'b1; step_cycle();
    check("sticky_after_clr", 32'(err_sticky_o), 1);
    check("err3_repaired", 32'(err_o[3]), 0);

    // Reset in the middle of activity on every channel.
    idle();
    for (int k = 0; k < NCH; k++) do_set(k, k + 12);
    step_cycle();
    idle();
    rst_i = 1'b1;
    for (int k = 0; k < NCH; k++) do_incr(k, 7, 1'b1);
    step_cycle();
    check("mid_rst_cnt", 32'(cnt_o), 32'h0);
    check("mid_rst_wrap", 32'(wrap_o), 32'h0);
    check("mid_rst_sticky", 32'(err_sticky_o), 32'h0);
    idle();
    step_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
